psram_access_scheduler: RTL

- Sequences and shares the octal PSRAM operator between two requesters: the camera write path (FIFO → PSRAM) and the UART upload path (PSRAM → UART).
- Arbitrates requests, drives the operator's enable and 2-bit command, and waits for the frame-done pulses.
- Enforces a CE recovery gap between operations and aborts hung operations with a watchdog.
- Sits between the capture/UART control logic and the PSRAM operator block.

---
 rtl/psram_sched_pkg.sv | 31 +++
 rtl/psram_sched_watchdog.sv | 44 ++++
 rtl/psram_access_scheduler.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/psram_sched_pkg.sv
// Shared types and constants for the PSRAM access scheduler.
package psram_sched_pkg;

    // Scheduler states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_RUN = 2'd1,
        RD_RUN = 2'd2,
        GAP    = 2'd3
    } sched_state_e;

    // Operator command encoding: {is_read, is_burst}
    localparam logic [1:0] CMD_SINGLE_WR = 2'b00;
    localparam logic [1:0] CMD_BURST_WR  = 2'b01;
    localparam logic [1:0] CMD_SINGLE_RD = 2'b10;
    localparam logic [1:0] CMD_BURST_RD  = 2'b11;

    // Default configuration
    localparam int unsigned DEF_GAP_CYCLES     = 8;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 65535;
    localparam int unsigned DEF_CNT_W          = 16;

    // Watchdog width covers the largest legal timeout (2^20-1)
    localparam int unsigned WD_W = 20;

    // Build the operator command from direction and burst mode
    function automatic logic [1:0] op_cmd(input logic is_rd, input logic burst);
        return {is_rd, burst};
    endfunction

endpackage

// File: rtl/psram_sched_watchdog.sv
// Loadable up-counter with clear, enable and terminal-count flag.
// Shared between the RUN-state timeout and the GAP countdown.
module psram_sched_watchdog
    import psram_sched_pkg::*;
#(
    parameter int unsigned W = WD_W
) (
    input  logic         iClk,
    input  logic         iRst_N,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear beats load beats increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/psram_access_scheduler.sv
// Shares the octal PSRAM operator between the camera write path and the
// UART upload path: arbitration, command drive, done/ack handling, CE
// recovery gap and a hung-operation watchdog.
// Build option: define PSRAM_SCHED_WR_PRIORITY_EN for strict write priority;
// default build uses round-robin between the two requesters.
module psram_access_scheduler
    import psram_sched_pkg::*;
#(
    parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic             iClk,
    input  logic             iRst_N,
    input  logic             iWrReq,
    input  logic             iRdReq,
    input  logic             iBurst,
    input  logic             iErrClr,
    output logic             oOpEn,
    output logic [1:0]       oOpCmd,
    input  logic             iWrFrameDone,
    input  logic             iRdFrameDone,
    output logic             oWrAck,
    output logic             oRdAck,
    output logic             oBusy,
    output logic             oTimeout,
    output logic [CNT_W-1:0] oWrFrameCnt,
    output logic [CNT_W-1:0] oRdFrameCnt
);

    localparam logic [WD_W-1:0] GAP_TERM = WD_W'(GAP_CYCLES);
    localparam logic [WD_W-1:0] TMO_TERM = WD_W'(TIMEOUT_CYCLES);

    sched_state_e     state_q;
    logic             op_en_q;
    logic [1:0]       op_cmd_q;
    logic             wr_ack_q;
    logic             rd_ack_q;
    logic             busy_q;
    logic             timeout_q;
    logic [CNT_W-1:0] wr_cnt_q;
    logic [CNT_W-1:0] rd_cnt_q;

    logic             any_req;
    logic             grant_rd;
    logic             in_run;
    logic             done_hit;
    logic             run_end;
    logic             wd_clr;
    logic             wd_load;
    logic             wd_en;
    logic             wd_tc;
    logic [WD_W-1:0]  wd_term;

    assign any_req = iWrReq | iRdReq;

`ifdef PSRAM_SCHED_WR_PRIORITY_EN
    // Camera writes always win; a read is granted only when no write waits
    assign grant_rd = ~iWrReq;
`else
    logic last_rd_q;
    // Round-robin: on contention serve whoever was not served last
    assign grant_rd = iRdReq & (~iWrReq | ~last_rd_q);
`endif

    // Only the done pulse matching the running direction counts
    assign in_run   = (state_q == WR_RUN) || (state_q == RD_RUN);
    assign done_hit = ((state_q == WR_RUN) && iWrFrameDone) ||
                      ((state_q == RD_RUN) && iRdFrameDone);
    assign run_end  = in_run && (done_hit || wd_tc);

    // Watchdog restarts at 0 on RUN entry, and at 1 on GAP entry so that
    // reaching GAP_CYCLES marks the last gap cycle
    assign wd_clr  = (state_q == IDLE) && any_req;
    assign wd_load = run_end;
    assign wd_en   = (state_q != IDLE);
    assign wd_term = (state_q == GAP) ? GAP_TERM : TMO_TERM;

    psram_sched_watchdog #(
        .W(WD_W)
    ) u_watchdog (
        .iClk      (iClk),
        .iRst_N    (iRst_N),
        .clr_i     (wd_clr),
        .load_i    (wd_load),
        .load_val_i(WD_W'(1)),
        .en_i      (wd_en),
        .term_i    (wd_term),
        .tc_o      (wd_tc)
    );

    // Scheduler FSM with all outputs registered
    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            state_q   <= IDLE;
            op_en_q   <= 1'b0;
            op_cmd_q  <= CMD_SINGLE_WR;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
`ifndef PSRAM_SCHED_WR_PRIORITY_EN
            last_rd_q <= 1'b1;
`endif
        end else begin
            wr_ack_q <= 1'b0;
            rd_ack_q <= 1'b0;
            // A timeout set further down overrides this clear
            if (iErrClr) begin
                timeout_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q  <= grant_rd ? RD_RUN : WR_RUN;
                        op_en_q  <= 1'b1;
                        op_cmd_q <= op_cmd(grant_rd, iBurst);
                        busy_q   <= 1'b1;
`ifndef PSRAM_SCHED_WR_PRIORITY_EN
                        last_rd_q <= grant_rd;
`endif
                    end
                end
                WR_RUN, RD_RUN: begin
                    if (run_end) begin
                        state_q  <= GAP;
                        op_en_q  <= 1'b0;
                        op_cmd_q <= CMD_SINGLE_WR;
                        // Done beats a coincident timeout
                        if (done_hit) begin
                            if (state_q == WR_RUN) begin
                                wr_ack_q <= 1'b1;
                                wr_cnt_q <= wr_cnt_q + CNT_W'(1);
                            end else begin
                                rd_ack_q <= 1'b1;
                                rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                            end
                        end else begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (wd_tc) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign oOpEn       = op_en_q;
    assign oOpCmd      = op_cmd_q;
    assign oWrAck      = wr_ack_q;
    assign oRdAck      = rd_ack_q;
    assign oBusy       = busy_q;
    assign oTimeout    = timeout_q;
    assign oWrFrameCnt = wr_cnt_q;
    assign oRdFrameCnt = rd_cnt_q;

endmodule
